smg_scan_bcd: RTL
=================

SMG_SCAN_BCD -- requirements
Module: smg_scan_bcd

Interface
REQ-001 SHALL have parameter DIGITS, default 4, meaning the number of multiplexed digits (2..8).
REQ-002 SHALL have parameter DATA_W, default 12, meaning the binary input width (4..20).
REQ-003 SHALL have port clk_1khz, input, 1 bit, the scan and conversion clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1 bit; reset is rst, asynchronous, active-low.
REQ-005 SHALL have port data, input, DATA_W bits, the value to display.
REQ-006 SHALL have port load, input, 1 bit, a one-cycle strobe that samples data.
REQ-007 SHALL have port busy, output, 1 bit, high while a conversion is in progress.
REQ-008 SHALL have port smg_sig, output, DIGITS bits, a one-hot digit select; bit DIGITS-1-i is high while digit i is driven (digit 0 is least significant).
REQ-009 SHALL have port smg_data, output, 8 bits, active-high segments: A..G on bits 0..6, DP on bit 7.

Function
REQ-010 SHALL use glyphs 0..9 = 3F,06,5B,4F,66,6D,7D,07,7F,6F (hex); blank = 00; dash = 40.
REQ-011 SHALL use an FSM with states IDLE, CONV and COMMIT.
REQ-012 In IDLE, load=1 SHALL capture data, go to CONV and raise busy on the next edge.
REQ-013 CONV SHALL run a shift-add-3 binary-to-BCD conversion, one bit per cycle, for exactly DATA_W cycles.
REQ-014 COMMIT SHALL atomically update the display register, drop busy and return to IDLE; busy is high for DATA_W+1 cycles.
REQ-015 load while busy=1 SHALL be ignored, with no queueing.
REQ-016 The displayed value SHALL change only in COMMIT; the scan never shows partial BCD.
REQ-017 A captured value greater than 10^N-1 SHALL display dashes on all N numeric digits, where N is the numeric digit count.
REQ-018 Leading-zero blanking SHALL apply: digits above the most significant nonzero digit are blank, and digit 0 always shows a glyph, so 0 displays as "0".
REQ-019 The scan counter SHALL advance one digit per clock from 0 to DIGITS-1 and wrap to 0.
REQ-020 smg_sig and smg_data SHALL be registered together so they always correspond to the same digit.
REQ-021 Scanning SHALL be independent of the FSM; conversion and load never pause it.
REQ-022 DP (bit 7) SHALL always be 0.

Reset
REQ-023 Reset SHALL set FSM=IDLE, busy=0, scan counter=0, smg_sig=0 and smg_data=00.
REQ-024 Reset SHALL set the display register to "0" on digit 0 and blank on all other digits.
REQ-025 Reset mid-conversion SHALL abort the conversion with no commit.
REQ-026 The first edge after reset release SHALL drive digit 0.

Configuration
REQ-027 With SMG_SIGN_EN defined, data SHALL be two's complement and the magnitude SHALL be converted.
REQ-028 With SMG_SIGN_EN defined, digit DIGITS-1 SHALL be the sign digit (dash if negative, blank otherwise) and N=DIGITS-1.
REQ-029 With SMG_SIGN_EN defined, the most negative value's magnitude SHALL be computed in DATA_W unsigned bits without loss.
REQ-030 Without SMG_SIGN_EN, data SHALL be unsigned and N=DIGITS.

Structure
REQ-031 Package smg_pkg SHALL hold the segment glyph constants, the blank and dash constants, the FSM state typedef and the BCD-digit-to-segment function.
REQ-032 Sub-module smg_bin2bcd SHALL contain the sequential converter (start, done, bcd out) with parameters DATA_W and N.
REQ-033 The top level SHALL contain the FSM handshake, the overflow/blank/sign formatting and the scan.

Verification (DIGITS=4, DATA_W=12 unless stated)
REQ-034 Reset, then load 26 -> busy high for 13 cycles, then digit0=7D, digit1=5B, digit2=00, digit3=00, repeating every 4 clocks.
REQ-035 Load 0 -> digit0=3F, digits 1-3=00; load 4095 -> digits 3..0 = 66,3F,6F,6D.
REQ-036 Load 26, then load 99 three cycles later -> 99 is ignored and the display shows 26.
REQ-037 DATA_W=14, load 12000 -> all four digits = 40.
REQ-038 With SMG_SIGN_EN, load 12'hFF6 -> digit3=40, digit2=00, digit1=06, digit0=3F; load 12'h800 -> dashes on digits 0-2 (2048>999).
REQ-039 Assert rst at CONV cycle 5 -> busy=0 and smg_data=00 immediately; after release, load 7 -> digit0=07.

Source files
------------

// File: rtl/smg_pkg.sv
//------------------------------------------------------------------------------
// smg_pkg
// Segment glyphs, the conversion FSM state type and the BCD-to-segment decoder
// for the multiplexed seven-segment display.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package smg_pkg;

   // Active-high segments: A..G on bits 0..6, DP on bit 7
   localparam logic [7:0] c_SEG_0     = 8'h3F;
   localparam logic [7:0] c_SEG_1     = 8'h06;
   localparam logic [7:0] c_SEG_2     = 8'h5B;
   localparam logic [7:0] c_SEG_3     = 8'h4F;
   localparam logic [7:0] c_SEG_4     = 8'h66;
   localparam logic [7:0] c_SEG_5     = 8'h6D;
   localparam logic [7:0] c_SEG_6     = 8'h7D;
   localparam logic [7:0] c_SEG_7     = 8'h07;
   localparam logic [7:0] c_SEG_8     = 8'h7F;
   localparam logic [7:0] c_SEG_9     = 8'h6F;
   localparam logic [7:0] c_SEG_BLANK = 8'h00;
   localparam logic [7:0] c_SEG_DASH  = 8'h40;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CONV   = 2'd1,
      ST_COMMIT = 2'd2
   } smg_state_t;

   function automatic logic [7:0] bcd_to_seg(input logic [3:0] i_bcd);
      logic [7:0] v_seg;
      case (i_bcd)
         4'd0:    v_seg = c_SEG_0;
         4'd1:    v_seg = c_SEG_1;
         4'd2:    v_seg = c_SEG_2;
         4'd3:    v_seg = c_SEG_3;
         4'd4:    v_seg = c_SEG_4;
         4'd5:    v_seg = c_SEG_5;
         4'd6:    v_seg = c_SEG_6;
         4'd7:    v_seg = c_SEG_7;
         4'd8:    v_seg = c_SEG_8;
         4'd9:    v_seg = c_SEG_9;
         default: v_seg = c_SEG_BLANK;
      endcase
      return v_seg;
   endfunction

endpackage

`default_nettype wire

// File: rtl/smg_bin2bcd.sv
//------------------------------------------------------------------------------
// smg_bin2bcd
// Sequential shift-add-3 binary-to-BCD converter, one input bit per clock.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module smg_bin2bcd #(
   parameter int DATA_W = 12,
   parameter int N      = 4
) (
   input  logic              clk_1khz,
   input  logic              rst,
   input  logic              i_start,
   input  logic [DATA_W-1:0] i_bin,
   output logic              o_done,
   output logic              o_ovf,
   output logic [4*N-1:0]    o_bcd
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   logic [DATA_W-1:0] r_bin;
   logic [4*N-1:0]    r_bcd;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_active;
   logic              r_ovf;
   logic [4*N-1:0]    w_adj;

   always_comb begin
      w_adj = r_bcd;
      for (int d = 0; d < N; d++) begin
         if (r_bcd[4*d +: 4] >= 4'd5) begin
            w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
         end
      end
   end

   // A 1 leaving the top digit means the value no longer fits in N digits;
   // the flag is sticky so later shifts cannot hide it.
   always_ff @(posedge clk_1khz or negedge rst) begin
      if (!rst) begin
         r_bin    <= '0;
         r_bcd    <= '0;
         r_cnt    <= '0;
         r_active <= 1'b0;
         r_ovf    <= 1'b0;
      end else if (i_start) begin
         r_bin    <= i_bin;
         r_bcd    <= '0;
         r_cnt    <= '0;
         r_active <= 1'b1;
         r_ovf    <= 1'b0;
      end else if (r_active) begin
         r_bcd <= {w_adj[4*N-2:0], r_bin[DATA_W-1]};
         r_bin <= {r_bin[DATA_W-2:0], 1'b0};
         r_ovf <= r_ovf | w_adj[4*N-1];
         r_cnt <= r_cnt + 1'b1;
         if (r_cnt == CNT_W'(DATA_W - 1)) begin
            r_active <= 1'b0;
         end
      end
   end

   // High during the cycle whose closing edge performs the final shift
   assign o_done = r_active && (r_cnt == CNT_W'(DATA_W - 1));
   assign o_ovf  = r_ovf;
   assign o_bcd  = r_bcd;

endmodule

`default_nettype wire

// File: rtl/smg_scan_bcd.sv
//------------------------------------------------------------------------------
// smg_scan_bcd
// Binary-to-BCD display driver with blanking/overflow formatting and digit scan.
// Optional signed mode: define SMG_SIGN_EN (top digit becomes the sign digit).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module smg_scan_bcd #(
   parameter int DIGITS = 4,
   parameter int DATA_W = 12
) (
   input  logic              clk_1khz,
   input  logic              rst,
   input  logic [DATA_W-1:0] data,
   input  logic              load,
   output logic              busy,
   output logic [DIGITS-1:0] smg_sig,
   output logic [7:0]        smg_data
);

   import smg_pkg::*;

`ifdef SMG_SIGN_EN
   localparam int N = DIGITS - 1;
`else
   localparam int N = DIGITS;
`endif
   localparam int SCAN_W = $clog2(DIGITS);

   smg_state_t                r_state;
   logic [DIGITS-1:0][7:0]    r_disp;
   logic [DIGITS-1:0][7:0]    w_glyph;
   logic [SCAN_W-1:0]         r_scan;
   logic [DIGITS-1:0]         w_sel;
   logic [DATA_W-1:0]         w_mag;
   logic                      w_start;
   logic                      w_done;
   logic                      w_ovf;
   logic [4*N-1:0]            w_bcd;
   logic                      w_lead;

`ifdef SMG_SIGN_EN
   logic r_neg;

   // Two's-complement negate in DATA_W bits: the most negative value maps to
   // 2^(DATA_W-1), which is still representable unsigned.
   assign w_mag = data[DATA_W-1] ? (~data + 1'b1) : data;
`else
   assign w_mag = data;
`endif

   assign w_start = (r_state == ST_IDLE) && load;

   smg_bin2bcd #(
      .DATA_W (DATA_W),
      .N      (N)
   ) u_bin2bcd (
      .clk_1khz (clk_1khz),
      .rst      (rst),
      .i_start  (w_start),
      .i_bin    (w_mag),
      .o_done   (w_done),
      .o_ovf    (w_ovf),
      .o_bcd    (w_bcd)
   );

   // Leading zeros are blanked walking down from the top; digit 0 always shows
   always_comb begin
      w_glyph = '0;
      w_lead  = 1'b1;
      for (int i = N - 1; i >= 0; i--) begin
         if (w_ovf) begin
            w_glyph[i] = c_SEG_DASH;
         end else if (w_lead && (i != 0) && (w_bcd[4*i +: 4] == 4'd0)) begin
            w_glyph[i] = c_SEG_BLANK;
         end else begin
            w_glyph[i] = bcd_to_seg(w_bcd[4*i +: 4]);
            w_lead     = 1'b0;
         end
      end
`ifdef SMG_SIGN_EN
      w_glyph[DIGITS-1] = r_neg ? c_SEG_DASH : c_SEG_BLANK;
`endif
   end

   always_ff @(posedge clk_1khz or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         busy    <= 1'b0;
         r_disp  <= '0;
         r_disp[0] <= c_SEG_0;
`ifdef SMG_SIGN_EN
         r_neg   <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (load) begin
                  r_state <= ST_CONV;
                  busy    <= 1'b1;
`ifdef SMG_SIGN_EN
                  r_neg   <= data[DATA_W-1];
`endif
               end
            end
            ST_CONV: begin
               if (w_done) begin
                  r_state <= ST_COMMIT;
               end
            end
            ST_COMMIT: begin
               r_disp  <= w_glyph;
               busy    <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      w_sel = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_scan == SCAN_W'(i)) begin
            w_sel[DIGITS-1-i] = 1'b1;
         end
      end
   end

   // Select and segments are registered together so they never disagree
   always_ff @(posedge clk_1khz or negedge rst) begin
      if (!rst) begin
         r_scan   <= '0;
         smg_sig  <= '0;
         smg_data <= c_SEG_BLANK;
      end else begin
         smg_sig  <= w_sel;
         smg_data <= r_disp[r_scan];
         r_scan   <= (r_scan == SCAN_W'(DIGITS - 1)) ? '0 : r_scan + 1'b1;
      end
   end

endmodule

`default_nettype wire
